// File: rtl/shift_reg_pkg.sv
// Shared definitions for the 8-bit PISO/SIPO shift-register pair:
// default width, assembly state encoding and bit-order constants.
package shift_reg_pkg;

    localparam int SR_WIDTH_DEFAULT = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } sr_state_e;

    localparam logic MSB_FIRST_C = 1'b1;
    localparam logic LSB_FIRST_C = 1'b0;

endpackage : shift_reg_pkg

// File: rtl/sipo_out_hold.sv
// Output holding register for the SIPO receiver: valid/ready handshake
// and sticky overrun detection when a completed word finds the register full.
module sipo_out_hold
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = SR_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] word,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             overrun
);

    logic accept;

    assign accept = out_valid & out_ready;

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (load) begin
            // A word being consumed this cycle frees the slot for the new one.
            if (!out_valid || out_ready) begin
                out_data  <= word;
                out_valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (accept) begin
            out_valid <= 1'b0;
        end
    end

endmodule : sipo_out_hold

// File: rtl/sipo_8_bit_rx.sv
// Serial-to-parallel receive stage: assembles WIDTH-bit words from the PISO
// stream, flags aborted frames and hands words to sipo_out_hold.
module sipo_8_bit_rx
    import shift_reg_pkg::*;
#(
    parameter int   WIDTH     = SR_WIDTH_DEFAULT,
    parameter logic MSB_FIRST = MSB_FIRST_C
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shift_en,
    input  logic             serial_in,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    output logic             frame_abort
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_next;
    logic [CNT_W-1:0] bit_cnt;
    sr_state_e        state;
    logic             word_done;

    assign state = (bit_cnt == '0) ? ST_IDLE : ST_SHIFT;

    // The candidate word includes the bit sampled this cycle.
    assign shreg_next = (MSB_FIRST == MSB_FIRST_C) ? {shreg[WIDTH-2:0], serial_in}
                                                   : {serial_in, shreg[WIDTH-1:1]};

    assign word_done = shift_en && (bit_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst_n) begin
            shreg       <= '0;
            bit_cnt     <= '0;
            frame_abort <= 1'b0;
        end else begin
            frame_abort <= 1'b0;
            if (shift_en) begin
                shreg   <= shreg_next;
                bit_cnt <= word_done ? '0 : bit_cnt + CNT_W'(1);
            end else if (state == ST_SHIFT) begin
                bit_cnt     <= '0;
                frame_abort <= 1'b1;
            end
        end
    end

    sipo_out_hold #(
        .WIDTH (WIDTH)
    ) u_out_hold (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (word_done),
        .word      (shreg_next),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .overrun   (overrun)
    );

endmodule : sipo_8_bit_rx

// File: tb/tb_sipo_8_bit_rx.sv
// Self-checking bench: MSB-first and LSB-first receivers share one stimulus
// stream and are compared each cycle against a frame-level reference model.
module tb_sipo_8_bit_rx;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         shift_en = 1'b0;
    logic         serial_in = 1'b0;
    logic         out_ready = 1'b0;

    logic [W-1:0] msb_data, lsb_data;
    logic         msb_valid, lsb_valid;
    logic         msb_overrun, lsb_overrun;
    logic         msb_abort, lsb_abort;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit           frame[$];
    logic [W-1:0] exp_msb_data, exp_lsb_data;
    logic         exp_valid, exp_overrun, exp_abort;

    always #5 clk = ~clk;

    sipo_8_bit_rx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk         (clk),
        .rst_n       (rst_n),
        .shift_en    (shift_en),
        .serial_in   (serial_in),
        .out_data    (msb_data),
        .out_valid   (msb_valid),
        .out_ready   (out_ready),
        .overrun     (msb_overrun),
        .frame_abort (msb_abort)
    );

    sipo_8_bit_rx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk         (clk),
        .rst_n       (rst_n),
        .shift_en    (shift_en),
        .serial_in   (serial_in),
        .out_data    (lsb_data),
        .out_valid   (lsb_valid),
        .out_ready   (out_ready),
        .overrun     (lsb_overrun),
        .frame_abort (lsb_abort)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // First received bit lands at the MSB (msb=1) or LSB (msb=0).
    function automatic logic [W-1:0] assemble(input bit msb);
        logic [W-1:0] w = '0;
        for (int i = 0; i < W; i++)
            if (frame[i]) w = w | (W'(1) << (msb ? (W - 1 - i) : i));
        return w;
    endfunction

    function automatic void model_reset();
        frame.delete();
        exp_msb_data = '0;
        exp_lsb_data = '0;
        exp_valid    = 1'b0;
        exp_overrun  = 1'b0;
        exp_abort    = 1'b0;
    endfunction

    function automatic void model_step(input bit sh, input bit si, input bit rdy);
        bit accept;
        accept    = exp_valid && rdy;
        exp_abort = 1'b0;
        if (sh) begin
            frame.push_back(si);
            if (frame.size() == W) begin
                if (!exp_valid || rdy) begin
                    exp_msb_data = assemble(1'b1);
                    exp_lsb_data = assemble(1'b0);
                    exp_valid    = 1'b1;
                end else begin
                    exp_overrun = 1'b1;
                end
                frame.delete();
            end else if (accept) begin
                exp_valid = 1'b0;
            end
        end else begin
            if (frame.size() != 0) begin
                frame.delete();
                exp_abort = 1'b1;
            end
            if (accept) exp_valid = 1'b0;
        end
    endfunction

    task automatic compare_model();
        check("msb_data",    32'(msb_data),    32'(exp_msb_data));
        check("lsb_data",    32'(lsb_data),    32'(exp_lsb_data));
        check("msb_valid",   32'(msb_valid),   32'(exp_valid));
        check("lsb_valid",   32'(lsb_valid),   32'(exp_valid));
        check("msb_overrun", 32'(msb_overrun), 32'(exp_overrun));
        check("lsb_overrun", 32'(lsb_overrun), 32'(exp_overrun));
        check("msb_abort",   32'(msb_abort),   32'(exp_abort));
        check("lsb_abort",   32'(lsb_abort),   32'(exp_abort));
    endtask

    // Inputs change 1 time unit after the rising edge; outputs sampled there too.
    task automatic step(input bit sh, input bit si, input bit rdy);
        shift_en  = sh;
        serial_in = si;
        out_ready = rdy;
        model_step(sh, si, rdy);
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic do_reset(input bit sh);
        rst_n     = 1'b1;
        shift_en  = sh;
        serial_in = 1'b1;
        out_ready = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        compare_model();
    endtask

    // Sends a word's bits MSB first; out_ready is raised only on the last bit.
    task automatic send_word(input logic [W-1:0] w, input bit rdy_last);
        for (int i = W - 1; i >= 0; i--)
            step(1'b1, w[i], (i == 0) ? rdy_last : 1'b0);
    endtask

    initial begin
        model_reset();
        #1;

        // Reset state
        do_reset(1'b0);
        check("rst_data", 32'(msb_data), 32'h0);
        check("rst_valid", 32'(msb_valid), 32'h0);

        // MSB-first word, then accept
        send_word(8'hBD, 1'b0);
        check("bd_msb", 32'(msb_data), 32'hBD);
        check("bd_lsb", 32'(lsb_data), 32'hBD);
        check("bd_valid", 32'(msb_valid), 32'h1);
        step(1'b0, 1'b0, 1'b1);
        check("bd_accepted", 32'(msb_valid), 32'h0);
        check("idle_no_abort", 32'(msb_abort), 32'h0);

        // Back-to-back with overrun
        do_reset(1'b0);
        send_word(8'hBD, 1'b0);
        send_word(8'h53, 1'b0);
        check("ovr_data_kept", 32'(msb_data), 32'hBD);
        check("ovr_flag", 32'(msb_overrun), 32'h1);

        // Back-to-back with acceptance on the completing cycle
        do_reset(1'b0);
        send_word(8'hBD, 1'b0);
        send_word(8'h53, 1'b1);
        check("b2b_msb", 32'(msb_data), 32'h53);
        check("b2b_lsb", 32'(lsb_data), 32'hCA);
        check("b2b_valid", 32'(msb_valid), 32'h1);
        check("b2b_no_ovr", 32'(msb_overrun), 32'h0);

        // Abort after 5 bits
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("abort_pulse", 32'(msb_abort), 32'h1);
        check("abort_no_valid", 32'(msb_valid), 32'h0);
        step(1'b0, 1'b0, 1'b0);
        check("abort_one_cycle", 32'(msb_abort), 32'h0);
        send_word(8'h53, 1'b0);
        check("after_abort", 32'(msb_data), 32'h53);

        // Mid-word reset
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
        do_reset(1'b1);
        check("mid_rst_data", 32'(msb_data), 32'h0);
        check("mid_rst_abort", 32'(msb_abort), 32'h0);
        step(1'b0, 1'b0, 1'b0);
        check("mid_rst_no_abort", 32'(msb_abort), 32'h0);
        send_word(8'hA5, 1'b0);
        check("a5_msb", 32'(msb_data), 32'hA5);
        check("a5_lsb", 32'(lsb_data), 32'hA5);

        // Randomized traffic against the model
        do_reset(1'b0);
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0)
                do_reset(1'($urandom_range(0, 1)));
            else
                step(($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_sipo_8_bit_rx

// File: doc/sipo_8_bit_rx.md
# sipo_8_bit_rx

Serial-to-parallel receive stage that consumes the serial stream from the 8-bit PISO shift register and rebuilds whole words. It counts bits while shifting is enabled, moves each completed word into a holding register, and presents it with a valid/ready handshake. Overrun and aborted-frame conditions are flagged. It sits directly downstream of the PISO, on the same clock.

## Interface
- `WIDTH`, default 8: word width in bits; must be at least 2.
- `MSB_FIRST`, default 1:
  - 1: the first serial bit becomes `out_data[WIDTH-1]`.
  - 0: the first serial bit becomes `out_data[0]`.
- `clk`  input  1: single clock; all logic updates on the rising edge.
- `rst_n`  input  1: synchronous, active-high reset. Asserted when 1, sampled on the `clk` rising edge.
- `shift_en`  input  1: 1 means `serial_in` carries a valid bit this cycle. It mirrors the PISO's `sel_p_s`, where 0 means load/idle.
- `serial_in`  input  1: serial data bit, sampled only when `shift_en`=1.
- `out_data`  output  WIDTH: holding register contents.
- `out_valid`  output  1: the holding register holds an unconsumed word.
- `out_ready`  input  1: consumer accepts the word; the handshake completes on a cycle with `out_valid`=1 and `out_ready`=1.
- `overrun`  output  1: sticky flag; a completed word was dropped because the holding register was full.
- `frame_abort`  output  1: one-cycle pulse; a partial word was discarded.

## Operation
- Internal state:
  - `shreg[WIDTH-1:0]`, the shift register.
  - `bit_cnt`, range 0..WIDTH-1, width $clog2(WIDTH).
  - The holding register plus its `out_valid`.
- States:
  - **IDLE**: `bit_cnt`=0.
  - **SHIFT**: 0 < `bit_cnt` < WIDTH.
  - The full/not-full status of the holding register is tracked independently by `out_valid`.
- `shift_en`=1, IDLE or SHIFT:
  - Sample `serial_in`.
  - With MSB_FIRST=1, shift left with the new bit at the LSB; otherwise shift right with the new bit at the MSB.
  - `bit_cnt` increments.
- Word completion: a cycle with `shift_en`=1 and `bit_cnt`=WIDTH-1.
  - The assembled word, including this cycle's bit, is the candidate.
  - `bit_cnt` wraps to 0.
  - If the holding register is empty, or is being consumed this cycle (`out_ready`=1), the candidate loads and `out_valid`=1.
  - Otherwise the candidate is dropped, the held word is kept, and `overrun` sets.
- `shift_en`=0 with `bit_cnt`≠0:
  - The partial word is discarded and `bit_cnt` returns to 0.
  - `frame_abort` pulses for 1 cycle.
  - `shreg` contents are don't-care.
- `shift_en`=0 with `bit_cnt`=0: no state change and no pulse.
- Handshake:
  - `out_valid` falls after a cycle with `out_valid` & `out_ready`, unless a new word loads in that same cycle.
  - `out_data` is stable while `out_valid`=1 and not yet accepted.
- `overrun` clears only on reset.

## Timing
- Reset values: `out_data`=0, `out_valid`=0, `overrun`=0, `frame_abort`=0; `bit_cnt`=0, `shreg`=0.
- Reset takes priority over every other event and is allowed mid-word; the partial word is lost and no `frame_abort` is raised.
- Latency: the last bit is sampled on edge N, and `out_data`/`out_valid` are valid after edge N. A word therefore takes WIDTH consecutive `shift_en` cycles.
- Back-to-back words are supported with no gap cycles.
- Simultaneous completion and acceptance: the new word replaces the old one, `out_valid` stays 1, and no overrun is raised.
- `frame_abort` is registered: it is high for the cycle after the edge that sampled `shift_en`=0.
- No combinational path from inputs to outputs.

## Structure
- Shared package `shift_reg_pkg` holds:
  - `SR_WIDTH_DEFAULT` = 8.
  - The state enum `{ST_IDLE, ST_SHIFT}`.
  - A bit-order constant pair `MSB_FIRST_C`/`LSB_FIRST_C`, for reuse by the PISO.
- One sub-module is natural: `sipo_out_hold`. It covers the holding register, the valid/ready logic and overrun detection, and keeps the handshake separate from the bit-assembly logic.
- Target size: roughly 150–250 RTL lines in total.

## Test plan
- **MSB-first word**: reset, then `shift_en`=1 for 8 cycles with bits 1,0,1,1,1,1,0,1 and `out_ready`=0.
  - Expect `out_data`=8'hBD and `out_valid`=1 after the 8th edge.
  - Then pulse `out_ready` and expect `out_valid`=0.
- **Back-to-back with overrun**: send 8'hBD then 8'h53 in 16 consecutive cycles with `out_ready`=0.
  - Expect `out_data` to stay 8'hBD and `overrun`=1.
  - Repeat with `out_ready`=1 during the 16th cycle: expect `out_data`=8'h53, `out_valid`=1 and `overrun`=0.
- **Abort**: drop `shift_en` after 5 bits.
  - Expect a `frame_abort` pulse for exactly 1 cycle and `out_valid` to stay 0.
  - A following full 8'h53 frame must yield 8'h53.
- **Mid-word reset**: assert `rst_n`=1 for 1 cycle after 3 bits.
  - Expect all outputs at 0 and no `frame_abort`.
  - The next 8-bit frame of 8'hA5 must yield 8'hA5.
- **LSB-first**: with `MSB_FIRST`=0, send bits 1,0,1,1,1,1,0,1 and expect `out_data`=8'hBD reversed, which is 8'hBD (palindrome check).
  - Repeat with 8'h53's MSB-first bit sequence and expect 8'hCA.
